// File: rtl/seq_chunk_adder.sv
// Multi-cycle ripple-carry adder/subtractor.
// Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, with a registered carry
// between chunks. One operation is in flight at a time, using valid/ready on both sides.
`timescale 1ns / 1ps

module seq_chunk_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (CHUNK == 0 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_chunk;
  logic             msb_carry_in;

  // One chunk of the ripple add, selected by the current chunk index.
  always_comb begin
    a_chunk = a_q[idx_q*CHUNK +: CHUNK];
    b_chunk = b_q[idx_q*CHUNK +: CHUNK];
    {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK + 1)'(carry_q);
    // Only meaningful on the last chunk: recovers the carry into the sign bit.
    msb_carry_in = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s_chunk[CHUNK-1];
  end

  // Next-state logic: capture operands in idle, ripple one chunk per cycle in run.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        res_d[idx_q*CHUNK +: CHUNK] = s_chunk;
        carry_d = c_chunk;
        if (idx_q == LAST_IDX) begin
          cout_d  = c_chunk;
          ovf_d   = c_chunk ^ msb_carry_in;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    res       = res_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: two configurations (32/8 and 4/4) driven side by side.
// Expected results go into per-configuration queues when an operand is accepted; a monitor
// pops and compares at each result handshake.
`timescale 1ns / 1ps

module tb_seq_chunk_adder;

  localparam int NCFG  = 2;
  localparam int NRAND = 4000;
  localparam int BOUND = 200;

  typedef struct packed {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]     a_s [NCFG];
  logic [31:0]     b_s [NCFG];
  logic [NCFG-1:0] sub_s;
  logic [NCFG-1:0] in_valid_s;
  logic [NCFG-1:0] out_ready_s;
  wire  [NCFG-1:0] in_ready_w;
  wire  [NCFG-1:0] out_valid_w;
  wire  [NCFG-1:0] cout_w;
  wire  [NCFG-1:0] ovf_w;
  wire  [31:0]     res_w [NCFG];

  int   checks = 0;
  int   failures = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   rand_phase = 1'b0;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int W = (g == 0) ? 32 : 4;
    localparam int C = (g == 0) ? 8 : 4;
    wire [W-1:0] r;
    seq_chunk_adder #(
      .WIDTH(W),
      .CHUNK(C)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid_s[g]),
      .in_ready (in_ready_w[g]),
      .a        (a_s[g][W-1:0]),
      .b        (b_s[g][W-1:0]),
      .sub      (sub_s[g]),
      .out_valid(out_valid_w[g]),
      .out_ready(out_ready_s[g]),
      .res      (r),
      .cout     (cout_w[g]),
      .ovf      (ovf_w[g])
    );
    assign res_w[g] = 32'(r);
  end

  function automatic int cfg_w(int c);
    return (c == 0) ? 32 : 4;
  endfunction

  // Reference: whole-word arithmetic, overflow from operand/result sign rules.
  function automatic exp_t model(int c, logic [31:0] a, logic [31:0] b, logic s);
    int          w;
    logic [32:0] mask;
    logic [32:0] full;
    logic        sa, sb, sr;
    exp_t        e;
    w      = cfg_w(c);
    mask   = (33'd1 << w) - 33'd1;
    full   = ({1'b0, a} & mask) + ((s ? ~{1'b0, b} : {1'b0, b}) & mask) + 33'(s);
    e.res  = full[31:0] & mask[31:0];
    e.cout = full[w];
    sa     = a[w-1];
    sb     = b[w-1];
    sr     = e.res[w-1];
    e.ovf  = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void push(int c, exp_t e);
    if (c == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  // Drive one operation and record its expected result at the accepting edge.
  task automatic issue(int c, logic [31:0] a, logic [31:0] b, logic s);
    int n;
    n = 0;
    @(negedge clk);
    a_s[c] = a;
    b_s[c] = b;
    sub_s[c] = s;
    in_valid_s[c] = 1'b1;
    while (!in_ready_w[c] && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= BOUND) begin
      failures++;
      $display("FAIL cfg%0d_accept_timeout waited=%0d limit=%0d", c, n, BOUND);
      in_valid_s[c] = 1'b0;
    end else begin
      push(c, model(c, a, b, s));
      @(posedge clk);
      #1;
      in_valid_s[c] = 1'b0;
      // Operands are don't-care once captured.
      a_s[c] = $urandom;
      b_s[c] = $urandom;
      sub_s[c] = 1'($urandom);
    end
  endtask

  // Count rising edges until out_valid; called just after the accepting edge.
  task automatic wait_valid(int c, output int lat);
    lat = 0;
    while (!out_valid_w[c] && lat < BOUND) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid_w[c]) begin
      checks++;
      failures++;
      $display("FAIL cfg%0d_result_timeout waited=%0d limit=%0d", c, lat, BOUND);
    end
  endtask

  task automatic rand_ops(int c);
    logic [31:0] corners [4];
    logic [31:0] ra, rb;
    corners = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int i = 0; i < NRAND; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      issue(c, ra, rb, 1'($urandom_range(0, 1)));
    end
  endtask

  // Monitor: compare at every result handshake.
  always @(negedge clk) begin
    for (int c = 0; c < NCFG; c++) begin
      if (rst_n && out_valid_w[c] && out_ready_s[c]) begin
        exp_t e;
        int   sz;
        sz = (c == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
          checks++;
          failures++;
          $display("FAIL cfg%0d_unexpected_result actual=%h expected=none", c, res_w[c]);
        end else begin
          if (c == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk($sformatf("cfg%0d_res", c), res_w[c], e.res);
          chk($sformatf("cfg%0d_cout", c), 32'(cout_w[c]), 32'(e.cout));
          chk($sformatf("cfg%0d_ovf", c), 32'(ovf_w[c]), 32'(e.ovf));
        end
      end
    end
  end

  // Random backpressure during the random phase, changed away from the sampling edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_phase) begin
        for (int c = 0; c < NCFG; c++) out_ready_s[c] = ($urandom_range(0, 9) < 7);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    for (int c = 0; c < NCFG; c++) begin
      a_s[c] = '0;
      b_s[c] = '0;
    end
    sub_s = '0;
    in_valid_s = '0;
    out_ready_s = '1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < NCFG; c++) begin
      chk($sformatf("cfg%0d_rst_in_ready", c), 32'(in_ready_w[c]), 32'd1);
      chk($sformatf("cfg%0d_rst_out_valid", c), 32'(out_valid_w[c]), 32'd0);
      chk($sformatf("cfg%0d_rst_res", c), res_w[c], 32'd0);
      chk($sformatf("cfg%0d_rst_cout", c), 32'(cout_w[c]), 32'd0);
      chk($sformatf("cfg%0d_rst_ovf", c), 32'(ovf_w[c]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Carry ripples through every chunk; result four edges after accept.
    issue(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    wait_valid(0, lat);
    chk("t1_latency", lat, 4);
    chk("t1_res", res_w[0], 32'h0);
    chk("t1_cout", 32'(cout_w[0]), 32'd1);
    chk("t1_ovf", 32'(ovf_w[0]), 32'd0);

    // Subtraction with and without borrow.
    issue(0, 32'd5, 32'd7, 1'b1);
    wait_valid(0, lat);
    chk("t2a_res", res_w[0], 32'hFFFF_FFFE);
    chk("t2a_cout", 32'(cout_w[0]), 32'd0);
    chk("t2a_ovf", 32'(ovf_w[0]), 32'd0);
    issue(0, 32'd7, 32'd5, 1'b1);
    wait_valid(0, lat);
    chk("t2b_res", res_w[0], 32'd2);
    chk("t2b_cout", 32'(cout_w[0]), 32'd1);

    // Signed overflow in both directions.
    issue(0, 32'h7FFF_FFFF, 32'h1, 1'b0);
    wait_valid(0, lat);
    chk("t3a_res", res_w[0], 32'h8000_0000);
    chk("t3a_ovf", 32'(ovf_w[0]), 32'd1);
    chk("t3a_cout", 32'(cout_w[0]), 32'd0);
    issue(0, 32'h8000_0000, 32'h1, 1'b1);
    wait_valid(0, lat);
    chk("t3b_res", res_w[0], 32'h7FFF_FFFF);
    chk("t3b_ovf", 32'(ovf_w[0]), 32'd1);

    // Single-chunk configuration.
    issue(1, 32'd9, 32'd8, 1'b0);
    wait_valid(1, lat);
    chk("t6_latency", lat, 1);
    chk("t6_res", res_w[1], 32'd1);
    chk("t6_cout", 32'(cout_w[1]), 32'd1);
    chk("t6_ovf", 32'(ovf_w[1]), 32'd1);

    // Backpressure in DONE with a new request waiting.
    @(posedge clk);
    #1;
    out_ready_s[0] = 1'b0;
    issue(0, 32'h7FFF_FFFF, 32'h1, 1'b0);
    wait_valid(0, lat);
    a_s[0] = 32'h0000_0100;
    b_s[0] = 32'h0000_0023;
    sub_s[0] = 1'b0;
    in_valid_s[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_in_ready", 32'(in_ready_w[0]), 32'd0);
      chk("t4_hold_out_valid", 32'(out_valid_w[0]), 32'd1);
      chk("t4_hold_res", res_w[0], 32'h8000_0000);
      chk("t4_hold_cout", 32'(cout_w[0]), 32'd0);
      chk("t4_hold_ovf", 32'(ovf_w[0]), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready_s[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_in_ready_after_release", 32'(in_ready_w[0]), 32'd1);
    chk("t4_out_valid_after_release", 32'(out_valid_w[0]), 32'd0);
    push(0, model(0, 32'h0000_0100, 32'h0000_0023, 1'b0));
    @(posedge clk);
    #1;
    chk("t4_accepted", 32'(in_ready_w[0]), 32'd0);
    in_valid_s[0] = 1'b0;
    wait_valid(0, lat);
    chk("t4_second_res", res_w[0], 32'h0000_0123);

    // Reset while idx=2 aborts the operation; outputs clear without a clock edge.
    issue(0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 32'(out_valid_w[0]), 32'd0);
    chk("t5_in_ready", 32'(in_ready_w[0]), 32'd1);
    chk("t5_res", res_w[0], 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 32'd3, 32'd4, 1'b0);
    wait_valid(0, lat);
    chk("t5_next_res", res_w[0], 32'd7);

    // Random traffic on both configurations at once.
    @(posedge clk);
    rand_phase = 1'b1;
    fork
      rand_ops(0);
      rand_ops(1);
    join
    rand_phase = 1'b0;
    @(posedge clk);
    #1;
    out_ready_s = '1;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_cfg0", q0.size(), 0);
    chk("drain_cfg1", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
